// File: rtl/adc_serial_cfg_responder_pkg.sv
// Shared framing constants and FSM encoding for the extended-control serial
// link. The initiator and the responder both import this package, so the two
// ends always agree on the frame layout:
//   frame = {header[HEADER_BITS], addr[ADDR_BITS], data[DATA_BITS]}, MSB first.
package adc_serial_cfg_responder_pkg;

  localparam int FRAME_BITS  = 32;
  localparam int HEADER_BITS = 12;
  localparam int ADDR_BITS   = 4;
  localparam int DATA_BITS   = 16;
  localparam logic [HEADER_BITS-1:0] HEADER_VALUE = 12'h001;

  // The bit counter must be able to hold FRAME_BITS+1, which marks "too long".
  localparam int CNT_W = $clog2(FRAME_BITS + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/adc_serial_cfg_responder_sync_edge.sv
// cfg_sync_edge: multi-flop synchronizer with edge detect.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   din       asynchronous input
//   level     synchronized level
//   rise/fall one-cycle pulses on synchronized level transitions
// RST_VAL sets the idle level of the line so reset does not fabricate an edge.
// SYNC_STAGES must be at least 2.
module cfg_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev   <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/adc_serial_cfg_responder.sv
// adc_serial_cfg_responder: receives frames from the extended-control serial
// initiator (sclk/sdata/select, oversampled in the clk domain), reports each
// accepted register write as a one-cycle strobe, flags bad frames, and keeps
// a shadow register file readable with one cycle of latency.
// Ports:
//   clk, rst          system clock (>= 4x sclk), synchronous active-high reset
//   sclk, sdata       serial clock/data, data sampled on sclk rising edges
//   select            active-low frame enable
//   wr_valid          one-cycle pulse per accepted frame
//   wr_addr, wr_data  fields of the last accepted frame
//   frame_err         one-cycle pulse per rejected frame
//   busy              frame in progress
//   rd_addr, rd_data  shadow register read port (registered)
module adc_serial_cfg_responder
  import adc_serial_cfg_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 sdata,
  input  logic                 select,
  output logic                 wr_valid,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 frame_err,
  output logic                 busy,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sdata_lvl, unused_sdata_rise, unused_sdata_fall;
  logic sel_lvl, sel_rise, sel_fall;

  cfg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  cfg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdata (
    .clk(clk), .rst(rst), .din(sdata),
    .level(sdata_lvl), .rise(unused_sdata_rise), .fall(unused_sdata_fall)
  );

  cfg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sel (
    .clk(clk), .rst(rst), .din(select),
    .level(sel_lvl), .rise(sel_rise), .fall(sel_fall)
  );

  // Only the rising sclk edge and the select level/rise steer the FSM.
  logic unused_edges;
  assign unused_edges = sclk_lvl ^ sclk_fall ^ sel_fall;

  cfg_state_e state, state_nxt;

  logic [FRAME_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0]  shadow [2**ADDR_BITS];
  logic                  accept;

  assign accept = (bit_cnt == CNT_FULL) &&
                  (shift_reg[FRAME_BITS-1 -: HEADER_BITS] == HEADER_VALUE);

  // IDLE follows the select level rather than only its falling edge, so a
  // frame that starts while COMMIT is still running (or across a reset)
  // is picked up one cycle later instead of being lost.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!sel_lvl) state_nxt = SHIFT;
      SHIFT:   if (sel_rise) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_data   <= '0;
      for (int i = 0; i < 2**ADDR_BITS; i++) shadow[i] <= '0;
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      rd_data   <= shadow[rd_addr];
      case (state)
        IDLE: begin
          shift_reg <= '0;
          bit_cnt   <= '0;
        end
        SHIFT: begin
          // A bit arriving in the same cycle as sel_rise is still captured:
          // COMMIT evaluates on the following cycle.
          if (sclk_rise) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], sdata_lvl};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        COMMIT: begin
          if (accept) begin
            wr_valid <= 1'b1;
            wr_addr  <= shift_reg[DATA_BITS +: ADDR_BITS];
            wr_data  <= shift_reg[DATA_BITS-1:0];
            shadow[shift_reg[DATA_BITS +: ADDR_BITS]] <= shift_reg[DATA_BITS-1:0];
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_adc_serial_cfg_responder.sv
module tb_adc_serial_cfg_responder;
  import adc_serial_cfg_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        sdata = 1'b0;
  logic        select = 1'b1;
  logic [3:0]  rd_addr = 4'h0;
  logic        wr_valid, frame_err, busy;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data, rd_data;

  always #5 clk = ~clk;

  adc_serial_cfg_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sdata(sdata), .select(select),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  int vectors = 0;
  int miscompares = 0;

  // Observation of DUT strobes (counts high cycles, so a stretched pulse shows up).
  int          wv_cnt = 0, fe_cnt = 0, both_cnt = 0;
  logic [19:0] got_q[$];

  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      wv_cnt++;
      got_q.push_back({wr_addr, wr_data});
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (wr_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
  end

  // Reference model: a frame is a write iff it has exactly 32 bits and the
  // right header; otherwise it is an error. Shadow file is a plain array.
  int          exp_wv = 0, exp_fe = 0;
  logic [19:0] exp_q[$];
  logic [15:0] model_shadow[16];

  task automatic model_frame(input logic [63:0] v, input int n);
    if (n == 32 && v[31:20] == 12'h001) begin
      exp_wv++;
      model_shadow[v[19:16]] = v[15:0];
      exp_q.push_back(v[19:0]);
    end else begin
      exp_fe++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_shadow[i] = 16'h0;
  endtask

  // sclk = clk/8: 40 ns half period; all stimulus lands on clk falling edges.
  task automatic frame_start();
    @(negedge clk);
    select = 1'b0;
    #40;
  endtask

  task automatic shift_bits(input logic [63:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      sdata = v[i];
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
  endtask

  task automatic frame_end();
    #40 select = 1'b1;
  endtask

  task automatic send_frame(input logic [63:0] v, input int n);
    frame_start();
    shift_bits(v, n - 1, 0);
    frame_end();
  endtask

  task automatic settle();
    #102;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (wr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if ({wr_addr, wr_data} !== 20'h0) begin miscompares++; $display("FAIL reset_wr_fields got %h want 0", {wr_addr, wr_data}); end
    vectors++; if (rd_data !== 16'h0) begin miscompares++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic [63:0] v;
    logic [19:0] g, e;
    v = 64'h0013_ABCD;
    frame_start();
    shift_bits(v, 31, 16);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_mid got %b want 1", busy); end
    shift_bits(v, 15, 0);
    frame_end();
    model_frame(v, 32);
    // wr_valid is due 4 clk cycles after select rises.
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (wr_valid !== 1'b0) begin miscompares++; $display("FAIL basic_latency_early got %b want 0", wr_valid); end
    @(negedge clk);
    vectors++; if (wr_valid !== 1'b1) begin miscompares++; $display("FAIL basic_latency got %b want 1", wr_valid); end
    vectors++; if (wr_addr !== 4'h3 || wr_data !== 16'hABCD) begin miscompares++; $display("FAIL basic_fields got %h/%h want 3/abcd", wr_addr, wr_data); end
    settle();
    vectors++; if (wv_cnt !== exp_wv) begin miscompares++; $display("FAIL basic_wv_count got %0d want %0d", wv_cnt, exp_wv); end
    vectors++; if (fe_cnt !== exp_fe) begin miscompares++; $display("FAIL basic_fe_count got %0d want %0d", fe_cnt, exp_fe); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_idle got %b want 0", busy); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL basic_write got %h want %h", g, e); end
    end
    rd_addr = 4'h3;
    @(posedge clk); @(negedge clk);
    vectors++; if (rd_data !== model_shadow[3]) begin miscompares++; $display("FAIL basic_rd_data got %h want %h", rd_data, model_shadow[3]); end
  endtask

  task automatic test_bad_header();
    logic [63:0] v;
    v = {32'h0, 12'h002, 4'h5, 16'h1234};
    send_frame(v, 32);
    model_frame(v, 32);
    settle();
    vectors++; if (fe_cnt !== exp_fe) begin miscompares++; $display("FAIL hdr_fe_count got %0d want %0d", fe_cnt, exp_fe); end
    vectors++; if (wv_cnt !== exp_wv) begin miscompares++; $display("FAIL hdr_wv_count got %0d want %0d", wv_cnt, exp_wv); end
    rd_addr = 4'h5;
    @(posedge clk); @(negedge clk);
    vectors++; if (rd_data !== model_shadow[5]) begin miscompares++; $display("FAIL hdr_shadow5 got %h want %h", rd_data, model_shadow[5]); end
  endtask

  task automatic test_short_long();
    logic [63:0] v;
    v = 64'h0015_1111;
    send_frame(v >> 12, 20);
    model_frame(v >> 12, 20);
    settle();
    vectors++; if (fe_cnt !== exp_fe) begin miscompares++; $display("FAIL short_fe_count got %0d want %0d", fe_cnt, exp_fe); end
    v = {31'h0, 1'b1, 32'h0015_2222};
    send_frame(v, 33);
    model_frame(v, 33);
    settle();
    vectors++; if (fe_cnt !== exp_fe) begin miscompares++; $display("FAIL long_fe_count got %0d want %0d", fe_cnt, exp_fe); end
    vectors++; if (wv_cnt !== exp_wv) begin miscompares++; $display("FAIL shortlong_wv_count got %0d want %0d", wv_cnt, exp_wv); end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      @(posedge clk); @(negedge clk);
      vectors++; if (rd_data !== model_shadow[a]) begin miscompares++; $display("FAIL shortlong_shadow%0d got %h want %h", a, rd_data, model_shadow[a]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v1, v2;
    logic [19:0] g, e;
    v1 = {32'h0, 12'h001, 4'h1, 16'h0001};
    v2 = {32'h0, 12'h001, 4'h1, 16'hFFFF};
    send_frame(v1, 32);
    model_frame(v1, 32);
    #158;  // with frame_start's alignment, select stays high 2 sclk periods
    send_frame(v2, 32);
    model_frame(v2, 32);
    settle();
    vectors++; if (wv_cnt !== exp_wv) begin miscompares++; $display("FAIL b2b_wv_count got %0d want %0d", wv_cnt, exp_wv); end
    vectors++; if (fe_cnt !== exp_fe) begin miscompares++; $display("FAIL b2b_fe_count got %0d want %0d", fe_cnt, exp_fe); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL b2b_write got %h want %h", g, e); end
    end
    rd_addr = 4'h1;
    @(posedge clk); @(negedge clk);
    vectors++; if (rd_data !== model_shadow[1]) begin miscompares++; $display("FAIL b2b_shadow1 got %h want %h", rd_data, model_shadow[1]); end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] v;
    v = {32'h0, 12'h001, 4'h7, 16'h5A5A};
    frame_start();
    shift_bits(v, 31, 16);
    rst = 1'b1;
    #10 rst = 1'b0;
    model_reset();
    shift_bits(v, 15, 0);
    frame_end();
    model_frame(v, 16);  // only the post-reset tail is seen: a short frame
    settle();
    vectors++; if (fe_cnt !== exp_fe) begin miscompares++; $display("FAIL rstmid_fe_count got %0d want %0d", fe_cnt, exp_fe); end
    vectors++; if (wv_cnt !== exp_wv) begin miscompares++; $display("FAIL rstmid_wv_count got %0d want %0d", wv_cnt, exp_wv); end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      @(posedge clk); @(negedge clk);
      vectors++; if (rd_data !== model_shadow[a]) begin miscompares++; $display("FAIL rstmid_shadow%0d got %h want %h", a, rd_data, model_shadow[a]); end
    end
  endtask

  task automatic test_random();
    logic [63:0] v;
    logic [11:0] hdr;
    logic [19:0] g, e;
    int          n, kind;
    for (int f = 0; f < 30; f++) begin
      kind = int'($urandom_range(0, 9));
      v = {32'h0, 12'h001, 4'($urandom), 16'($urandom)};
      n = 32;
      if (kind == 6) begin
        hdr = 12'($urandom);
        if (hdr == 12'h001) hdr = 12'h003;
        v[31:20] = hdr;
      end else if (kind == 7) begin
        n = int'($urandom_range(1, 31));
        v = {32'h0, $urandom};
      end else if (kind == 8) begin
        n = int'($urandom_range(33, 36));
        v = {$urandom, $urandom};
      end
      send_frame(v, n);
      model_frame(v, n);
      settle();
      vectors++; if (wv_cnt !== exp_wv) begin miscompares++; $display("FAIL rand%0d_wv_count got %0d want %0d", f, wv_cnt, exp_wv); end
      vectors++; if (fe_cnt !== exp_fe) begin miscompares++; $display("FAIL rand%0d_fe_count got %0d want %0d", f, fe_cnt, exp_fe); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        vectors++; if (g !== e) begin miscompares++; $display("FAIL rand%0d_write got %h want %h", f, g, e); end
      end
      got_q.delete();
      exp_q.delete();
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      @(posedge clk); @(negedge clk);
      vectors++; if (rd_data !== model_shadow[a]) begin miscompares++; $display("FAIL rand_shadow%0d got %h want %h", a, rd_data, model_shadow[a]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_header();
    test_short_long();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL strobe_overlap got %0d cycles want 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
